line_burst_adapter: RTL

Memory-side responder for the 256-bit `mem_rw_itf` line interface. It sits below the eviction write buffer, on the link that connects the cache hierarchy to physical memory. It acts as the server for whole-line reads and writes, and converts each one into a 4-beat, 64-bit burst transaction on the physical memory port. On reads it gathers the beats into a full line before responding upstream; on writes it serializes a latched line out one beat at a time.

---
 rtl/rv32i_types.sv | 18 +
 rtl/mem_rw_itf.sv | 18 +
 rtl/line_burst_adapter_control.sv | 83 ++++++++
 rtl/line_burst_adapter.sv | 64 ++++++
 4 files changed

// File: rtl/rv32i_types.sv
`default_nettype none
// Shared cache-hierarchy types: line/burst geometry and the memory adapter state encoding.
// Revision: 1.0
package rv32i_types;

  localparam int LINE_BITS  = 256;
  localparam int BURST_BITS = 64;
  localparam int BURSTS     = LINE_BITS / BURST_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } adapter_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_rw_itf.sv
`default_nettype none
// Whole-line read/write link between a cache level and the level below it.
// Revision: 1.0
interface mem_rw_itf;
  import rv32i_types::*;

  logic                 read;
  logic                 write;
  logic [31:0]          addr;
  logic [LINE_BITS-1:0] wdata;
  logic [LINE_BITS-1:0] rdata;
  logic                 resp;

  modport server (input read, write, addr, wdata, output rdata, resp);
  modport client (output read, write, addr, wdata, input rdata, resp);

endinterface
`default_nettype wire

// File: rtl/line_burst_adapter_control.sv
`default_nettype none
// Line adapter control: request acceptance, beat counting and Moore handshake outputs.
// Revision: 1.0
module line_burst_adapter_control
  import rv32i_types::*;
#(
  parameter int BURSTS    = 4,
  parameter int BEAT_BITS = $clog2(BURSTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_read_i,
  input  logic                 req_write_i,
  input  logic                 mem_resp_i,
  output logic [BEAT_BITS-1:0] beat_o,
  output logic                 load_line_o,
  output logic                 load_addr_o,
  output logic                 capture_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic                 resp_o
);

  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BURSTS - 1);

  adapter_state_t       state_q, state_d;
  logic [BEAT_BITS-1:0] beat_q, beat_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    load_line_o = 1'b0;
    load_addr_o = 1'b0;
    capture_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Write takes priority when both requests are raised together.
        if (req_write_i) begin
          state_d     = WR;
          beat_d      = '0;
          load_line_o = 1'b1;
          load_addr_o = 1'b1;
        end else if (req_read_i) begin
          state_d     = RD;
          beat_d      = '0;
          load_addr_o = 1'b1;
        end
      end
      RD: begin
        if (mem_resp_i) begin
          capture_o = 1'b1;
          beat_d    = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = DONE;
        end
      end
      WR: begin
        if (mem_resp_i) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign beat_o      = beat_q;
  assign mem_read_o  = (state_q == RD);
  assign mem_write_o = (state_q == WR);
  assign resp_o      = (state_q == DONE);

endmodule
`default_nettype wire

// File: rtl/line_burst_adapter.sv
`default_nettype none
// Serves whole-line reads/writes from above as 4-beat bursts on the physical memory port.
// Revision: 1.0
module line_burst_adapter #(
  parameter int LINE_BITS  = rv32i_types::LINE_BITS,
  parameter int BURST_BITS = rv32i_types::BURST_BITS,
  parameter int BURSTS     = LINE_BITS / BURST_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_rw_itf.server             upper,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [31:0]           mem_addr,
  output logic [BURST_BITS-1:0] mem_wdata,
  input  logic [BURST_BITS-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam int BEAT_BITS = $clog2(BURSTS);

  logic [BEAT_BITS-1:0] beat_w;
  logic                 load_line_w;
  logic                 load_addr_w;
  logic                 capture_w;
  logic                 resp_w;
  logic [LINE_BITS-1:0] line_q;
  logic [31:0]          addr_q;

  line_burst_adapter_control #(
    .BURSTS    (BURSTS),
    .BEAT_BITS (BEAT_BITS)
  ) u_control (
    .clk         (clk),
    .rst         (rst),
    .req_read_i  (upper.read),
    .req_write_i (upper.write),
    .mem_resp_i  (mem_resp),
    .beat_o      (beat_w),
    .load_line_o (load_line_w),
    .load_addr_o (load_addr_w),
    .capture_o   (capture_w),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .resp_o      (resp_w)
  );

  // Line buffer and address are pure data; only the control state needs a reset.
  always_ff @(posedge clk) begin
    if (load_addr_w) addr_q <= {upper.addr[31:5], 5'b0};
    if (load_line_w) begin
      line_q <= upper.wdata;
    end else if (capture_w) begin
      line_q[BURST_BITS*int'(beat_w) +: BURST_BITS] <= mem_rdata;
    end
  end

  assign mem_addr    = (mem_read || mem_write) ? addr_q : 32'd0;
  assign mem_wdata   = line_q[BURST_BITS*int'(beat_w) +: BURST_BITS];
  assign upper.rdata = line_q;
  assign upper.resp  = resp_w;

endmodule
`default_nettype wire
